// File: rtl/alu_top_pkg.sv
// alu_top_pkg: shared constants for the registered ALU.
//   unit_e    : execution-unit select carried on ALU_FUNC[3:2]
//   FN_*      : the sixteen 4-bit function codes
//   CMP_RES_* : result codes driven by the compare unit
package alu_top_pkg;

    typedef enum logic [1:0] {
        ARITH = 2'b00,
        LOGIC = 2'b01,
        CMP   = 2'b10,
        SHIFT = 2'b11
    } unit_e;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_MUL  = 4'd2;
    localparam logic [3:0] FN_DIV  = 4'd3;
    localparam logic [3:0] FN_AND  = 4'd4;
    localparam logic [3:0] FN_OR   = 4'd5;
    localparam logic [3:0] FN_NAND = 4'd6;
    localparam logic [3:0] FN_NOR  = 4'd7;
    localparam logic [3:0] FN_NOP  = 4'd8;
    localparam logic [3:0] FN_EQ   = 4'd9;
    localparam logic [3:0] FN_GT   = 4'd10;
    localparam logic [3:0] FN_LT   = 4'd11;
    localparam logic [3:0] FN_SRA  = 4'd12;  // A >> 1
    localparam logic [3:0] FN_SLA  = 4'd13;  // A << 1
    localparam logic [3:0] FN_SRB  = 4'd14;  // B >> 1
    localparam logic [3:0] FN_SLB  = 4'd15;  // B << 1

    localparam logic [1:0] CMP_RES_NONE = 2'd0;
    localparam logic [1:0] CMP_RES_EQ   = 2'd1;
    localparam logic [1:0] CMP_RES_GT   = 2'd2;
    localparam logic [1:0] CMP_RES_LT   = 2'd3;

endpackage

// File: rtl/alu_arith.sv
// alu_arith: registered unsigned add/sub/mul/div.
//   clk_i, rst_i (sync, active-high), en_i, a_i, b_i, op_i = ALU_FUNC[1:0]
//   res_o : result, carry_o : add carry / sub borrow, flag_o : unit valid
module alu_arith
    import alu_top_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [Width-1:0] res_o,
    output logic             carry_o,
    output logic             flag_o
);

    logic [Width:0]   wide_d;   // bit Width is carry (add) or borrow (sub)
    logic [Width-1:0] res_d, res_q;
    logic             carry_d, carry_q, flag_q;

    always_comb begin
        wide_d  = '0;
        res_d   = '0;
        carry_d = 1'b0;
        if (en_i) begin
            case ({ARITH, op_i})
                FN_ADD:  wide_d = {1'b0, a_i} + {1'b0, b_i};
                FN_SUB:  wide_d = {1'b0, a_i} - {1'b0, b_i};
                FN_MUL:  wide_d = {1'b0, a_i * b_i};
                default: wide_d = (b_i == '0) ? '0 : {1'b0, a_i / b_i};
            endcase
            res_d   = wide_d[Width-1:0];
            carry_d = wide_d[Width];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            res_q   <= res_d;
            carry_q <= carry_d;
            flag_q  <= en_i;
        end
    end

    assign res_o   = res_q;
    assign carry_o = carry_q;
    assign flag_o  = flag_q;

endmodule

// File: rtl/alu_cmp.sv
// alu_cmp: registered unsigned compare producing a small result code.
//   clk_i, rst_i (sync, active-high), en_i, a_i, b_i, op_i = ALU_FUNC[1:0]
//   res_o : zero-extended CMP_RES_* code, flag_o : unit valid
module alu_cmp
    import alu_top_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [Width-1:0] res_o,
    output logic             flag_o
);

    logic [1:0]       code_d;
    logic [Width-1:0] res_q;
    logic             flag_q;

    always_comb begin
        code_d = CMP_RES_NONE;
        if (en_i) begin
            case ({CMP, op_i})
                FN_EQ:   code_d = (a_i == b_i) ? CMP_RES_EQ : CMP_RES_NONE;
                FN_GT:   code_d = (a_i >  b_i) ? CMP_RES_GT : CMP_RES_NONE;
                FN_LT:   code_d = (a_i <  b_i) ? CMP_RES_LT : CMP_RES_NONE;
                default: code_d = CMP_RES_NONE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            res_q  <= {{(Width-2){1'b0}}, code_d};
            flag_q <= en_i;
        end
    end

    assign res_o  = res_q;
    assign flag_o = flag_q;

endmodule

// File: rtl/alu_decoder.sv
// alu_decoder: unit select to one-hot unit enables.
//   unit_i [1:0] : ALU_FUNC[3:2]
//   en_o   [3:0] : one-hot enable, indexed by unit_e
module alu_decoder
    import alu_top_pkg::*;
(
    input  logic [1:0] unit_i,
    output logic [3:0] en_o
);

    always_comb begin
        en_o         = '0;
        en_o[unit_i] = 1'b1;
    end

endmodule

// File: rtl/alu_logic.sv
// alu_logic: registered AND/OR/NAND/NOR.
//   clk_i, rst_i (sync, active-high), en_i, a_i, b_i, op_i = ALU_FUNC[1:0]
//   res_o : result, flag_o : unit valid
module alu_logic
    import alu_top_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [Width-1:0] res_o,
    output logic             flag_o
);

    logic [Width-1:0] res_d, res_q;
    logic             flag_q;

    always_comb begin
        res_d = '0;
        if (en_i) begin
            case ({LOGIC, op_i})
                FN_AND:  res_d = a_i & b_i;
                FN_OR:   res_d = a_i | b_i;
                FN_NAND: res_d = ~(a_i & b_i);
                default: res_d = ~(a_i | b_i);
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            flag_q <= en_i;
        end
    end

    assign res_o  = res_q;
    assign flag_o = flag_q;

endmodule

// File: rtl/alu_shift.sv
// alu_shift: registered one-bit logical shift of A or B, zero fill.
//   clk_i, rst_i (sync, active-high), en_i, a_i, b_i, op_i = ALU_FUNC[1:0]
//   res_o : result, flag_o : unit valid
module alu_shift
    import alu_top_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [Width-1:0] res_o,
    output logic             flag_o
);

    logic [Width-1:0] res_d, res_q;
    logic             flag_q;

    always_comb begin
        res_d = '0;
        if (en_i) begin
            case ({SHIFT, op_i})
                FN_SRA:  res_d = a_i >> 1;
                FN_SLA:  res_d = a_i << 1;
                FN_SRB:  res_d = b_i >> 1;
                default: res_d = b_i << 1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            flag_q <= en_i;
        end
    end

    assign res_o  = res_q;
    assign flag_o = flag_q;

endmodule

// File: rtl/alu_top.sv
// alu_top: registered ALU with four execution units, one enabled per cycle.
//   CLK, RST (sync, active-high), A, B, ALU_FUNC ([3:2] unit, [1:0] op)
//   Arith_OUT/Carry_OUT/Arith_Flag, Logic_OUT/Logic_Flag,
//   CMP_OUT/CMP_Flag, SHIFT_OUT/SHIFT_Flag : per-unit result and valid,
//   all with one cycle of latency; disabled units register zero.
module alu_top
    import alu_top_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    input  logic [3:0]       ALU_FUNC,
    output logic [Width-1:0] Arith_OUT,
    output logic             Carry_OUT,
    output logic             Arith_Flag,
    output logic [Width-1:0] Logic_OUT,
    output logic             Logic_Flag,
    output logic [Width-1:0] CMP_OUT,
    output logic             CMP_Flag,
    output logic [Width-1:0] SHIFT_OUT,
    output logic             SHIFT_Flag
);

    logic [3:0] unit_en;

    alu_decoder u_dec (
        .unit_i (ALU_FUNC[3:2]),
        .en_o   (unit_en)
    );

    alu_arith #(.Width(Width)) u_arith (
        .clk_i (CLK), .rst_i (RST), .en_i (unit_en[ARITH]),
        .a_i (A), .b_i (B), .op_i (ALU_FUNC[1:0]),
        .res_o (Arith_OUT), .carry_o (Carry_OUT), .flag_o (Arith_Flag)
    );

    alu_logic #(.Width(Width)) u_logic (
        .clk_i (CLK), .rst_i (RST), .en_i (unit_en[LOGIC]),
        .a_i (A), .b_i (B), .op_i (ALU_FUNC[1:0]),
        .res_o (Logic_OUT), .flag_o (Logic_Flag)
    );

    alu_cmp #(.Width(Width)) u_cmp (
        .clk_i (CLK), .rst_i (RST), .en_i (unit_en[CMP]),
        .a_i (A), .b_i (B), .op_i (ALU_FUNC[1:0]),
        .res_o (CMP_OUT), .flag_o (CMP_Flag)
    );

    alu_shift #(.Width(Width)) u_shift (
        .clk_i (CLK), .rst_i (RST), .en_i (unit_en[SHIFT]),
        .a_i (A), .b_i (B), .op_i (ALU_FUNC[1:0]),
        .res_o (SHIFT_OUT), .flag_o (SHIFT_Flag)
    );

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: directed-vector bench for alu_top with hand-computed results.
module tb_alu_top;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] A, B;
    logic [3:0]   ALU_FUNC;
    logic [W-1:0] Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT;
    logic         Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    alu_top #(.Width(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .A          (A),
        .B          (B),
        .ALU_FUNC   (ALU_FUNC),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .CMP_OUT    (CMP_OUT),
        .CMP_Flag   (CMP_Flag),
        .SHIFT_OUT  (SHIFT_OUT),
        .SHIFT_Flag (SHIFT_Flag)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Every output is checked: the selected unit carries res (and carry for
    // arithmetic), all others must be zero with their flags low.
    task automatic check_all(input string tag, input logic rst_cyc, input logic [3:0] f,
                             input logic [W-1:0] res, input logic cy);
        logic [1:0] u;
        u = f[3:2];
        check({tag, ".arith"}, 32'(Arith_OUT),  (!rst_cyc && u == 2'd0) ? 32'(res) : 32'd0);
        check({tag, ".carry"}, 32'(Carry_OUT),  (!rst_cyc && u == 2'd0) ? 32'(cy)  : 32'd0);
        check({tag, ".logic"}, 32'(Logic_OUT),  (!rst_cyc && u == 2'd1) ? 32'(res) : 32'd0);
        check({tag, ".cmp"},   32'(CMP_OUT),    (!rst_cyc && u == 2'd2) ? 32'(res) : 32'd0);
        check({tag, ".shift"}, 32'(SHIFT_OUT),  (!rst_cyc && u == 2'd3) ? 32'(res) : 32'd0);
        check({tag, ".flags"},
              32'({SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag}),
              rst_cyc ? 32'd0 : 32'(4'b0001 << u));
    endtask

    task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f,
                           input logic [W-1:0] res, input logic cy);
        @(negedge CLK);
        A = a; B = b; ALU_FUNC = f;
        @(posedge CLK);
        #1;
        check_all($sformatf("f%0d a%0h b%0h", f, a, b), 1'b0, f, res, cy);
    endtask

    initial begin
        logic [3:0]   seq_f [4];
        logic [W-1:0] seq_r [4];
        seq_f = '{4'd0, 4'd4, 4'd8, 4'd12};
        seq_r = '{16'd30, 16'd0, 16'd0, 16'd10};

        // Reset with arbitrary inputs that would otherwise produce nonzero results
        RST = 1'b1; A = 16'hFFFF; B = 16'hFFFF; ALU_FUNC = 4'd0;
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset", 1'b1, 4'd0, '0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        // Arithmetic
        run_vec(16'd10,   16'd20,  4'd0,  16'd30,    1'b0);
        run_vec(16'd20,   16'd10,  4'd1,  16'd10,    1'b0);
        run_vec(16'd20,   16'd10,  4'd2,  16'd200,   1'b0);
        run_vec(16'd20,   16'd10,  4'd3,  16'd2,     1'b0);
        run_vec(16'hFFFF, 16'd1,   4'd0,  16'd0,     1'b1);
        run_vec(16'd0,    16'd1,   4'd1,  16'hFFFF,  1'b1);
        run_vec(16'd300,  16'd300, 4'd2,  16'd24464, 1'b0);  // 90000 mod 65536
        run_vec(16'd20,   16'd0,   4'd3,  16'd0,     1'b0);
        run_vec(16'd7,    16'd7,   4'd1,  16'd0,     1'b0);

        // Logic
        run_vec(16'd20, 16'd10, 4'd4, 16'd0,     1'b0);
        run_vec(16'd20, 16'd10, 4'd5, 16'd30,    1'b0);
        run_vec(16'd20, 16'd10, 4'd6, 16'd65535, 1'b0);
        run_vec(16'd20, 16'd10, 4'd7, 16'd65505, 1'b0);

        // Compare
        run_vec(16'd20, 16'd10, 4'd8,  16'd0, 1'b0);
        run_vec(16'd20, 16'd10, 4'd9,  16'd0, 1'b0);
        run_vec(16'd20, 16'd10, 4'd10, 16'd2, 1'b0);
        run_vec(16'd20, 16'd10, 4'd11, 16'd0, 1'b0);
        run_vec(16'd5,  16'd5,  4'd9,  16'd1, 1'b0);
        run_vec(16'd5,  16'd5,  4'd10, 16'd0, 1'b0);
        run_vec(16'd3,  16'd7,  4'd11, 16'd3, 1'b0);
        run_vec(16'd3,  16'd7,  4'd10, 16'd0, 1'b0);

        // Shift
        run_vec(16'd20,   16'd3,  4'd12, 16'd10,    1'b0);
        run_vec(16'd20,   16'd3,  4'd13, 16'd40,    1'b0);
        run_vec(16'd3,    16'd20, 4'd14, 16'd10,    1'b0);
        run_vec(16'd3,    16'd20, 4'd15, 16'd40,    1'b0);
        run_vec(16'h8000, 16'd0,  4'd13, 16'd0,     1'b0);
        run_vec(16'h8000, 16'd0,  4'd12, 16'h4000,  1'b0);
        run_vec(16'd1,    16'h8001, 4'd14, 16'h4000, 1'b0);

        // Back-to-back unit switching, then reset mid-stream
        for (int i = 0; i < 8; i++)
            run_vec(16'd20, 16'd10, seq_f[i % 4], seq_r[i % 4], 1'b0);
        @(negedge CLK);
        RST = 1'b1; A = 16'd20; B = 16'd10; ALU_FUNC = 4'd0;
        @(posedge CLK);
        #1;
        check_all("midreset", 1'b1, 4'd0, '0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++)
            run_vec(16'd20, 16'd10, seq_f[i], seq_r[i], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
